// File: rtl/sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_frame_ctrl
// Sequencing controller for a serial-in/parallel-out frame receiver. A start
// bit (din=1 on an en tick while idle) opens a frame. WIDTH data bits are then
// shifted in MSB first, one per en tick. The finished word is moved into a
// holding register and offered on a valid/ready handshake. If a word completes
// while the previous one is still unconsumed, the new word is dropped and a
// sticky overrun flag is raised.
//
// Optional feature macro: SIPO_FRAME_PARITY_EN
//   When defined, one even-parity bit follows the data bits. Completion moves
//   to that parity tick, and parity_err = ^{word, parity bit} is registered
//   together with q_out. When undefined, parity_err is tied to 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   din        in   serial data line, idles at 0
//   en         in   sample tick; din is only looked at when en=1
//   ready      in   consumer accepts the word when valid && ready
//   clr_ovr    in   synchronous clear of overrun (a same-edge set wins)
//   q_out      out  held parallel word [WIDTH-1:0]
//   valid      out  q_out holds an unconsumed word
//   busy       out  frame reception in progress
//   overrun    out  sticky: a completed word was dropped
//   parity_err out  parity status of the held word
// -----------------------------------------------------------------------------
module sipo_frame_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] q_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sreg_r, sreg_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             done_s;   // a frame completes on this edge
  logic [WIDTH-1:0] word_s;   // word to load when done_s
  logic [WIDTH-1:0] q_r;
  logic             valid_r;
  logic             busy_r;
  logic             ovr_r;

`ifdef SIPO_FRAME_PARITY_EN
  logic             perr_s;
  logic             perr_r;

  // Even parity over data plus parity bit: 1 means the check failed.
  function automatic logic even_par(input logic [WIDTH-1:0] w, input logic b);
    return ^{w, b};
  endfunction
`endif

  // Next-state, shift and completion decode.
  always_comb begin
    state_s = state_r;
    sreg_s  = sreg_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    word_s  = sreg_r;
`ifdef SIPO_FRAME_PARITY_EN
    perr_s  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (en && din) begin
          state_s = SHIFT;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (en) begin
          sreg_s = {sreg_r[WIDTH-2:0], din};
          if (cnt_r == CNT_LAST) begin
            cnt_s = CNT_ZERO;
`ifdef SIPO_FRAME_PARITY_EN
            state_s = PARITY;
`else
            // Last data bit: the word leaves on this same edge.
            state_s = IDLE;
            done_s  = 1'b1;
            word_s  = {sreg_r[WIDTH-2:0], din};
`endif
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
            state_s = SHIFT;
          end
        end else begin
          state_s = SHIFT;
        end
      end
      PARITY: begin
`ifdef SIPO_FRAME_PARITY_EN
        if (en) begin
          state_s = IDLE;
          done_s  = 1'b1;
          word_s  = sreg_r;
          perr_s  = even_par(sreg_r, din);
        end else begin
          state_s = PARITY;
        end
`else
        state_s = IDLE;
`endif
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Receive-side state: FSM, shift register, bit counter, busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      sreg_r  <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sreg_r  <= sreg_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // Holding register, handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r     <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
      perr_r  <= 1'b0;
`endif
    end else begin
      // A drop sets overrun even if clr_ovr is asserted on the same edge.
      if (done_s && valid_r && !ready) begin
        ovr_r <= 1'b1;
      end else if (clr_ovr) begin
        ovr_r <= 1'b0;
      end
      // Load when the slot is empty or is being drained on this edge.
      if (done_s && (!valid_r || ready)) begin
        q_r     <= word_s;
        valid_r <= 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
        perr_r  <= perr_s;
`endif
      end else if (valid_r && ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign q_out   = q_r;
  assign valid   = valid_r;
  assign busy    = busy_r;
  assign overrun = ovr_r;
`ifdef SIPO_FRAME_PARITY_EN
  assign parity_err = perr_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sipo_frame_ctrl
// Self-checking bench for sipo_frame_ctrl (WIDTH=4). The reference model works
// at frame level: a word is a number, its serial image is computed from its
// bits, and the holding slot / overrun flag follow the handshake rules applied
// once per completed frame or consume/clear pulse.
// -----------------------------------------------------------------------------
module tb_sipo_frame_ctrl;

  localparam int WIDTH = 4;
`ifdef SIPO_FRAME_PARITY_EN
  localparam int NB = WIDTH + 1;   // en ticks after the start bit
`else
  localparam int NB = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             din = 1'b0;
  logic             en = 1'b0;
  logic             ready = 1'b0;
  logic             clr_ovr = 1'b0;
  logic [WIDTH-1:0] q_out;
  logic             valid;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  int n_pass  = 0;
  int n_total = 0;

  // Frame-level reference model
  logic [WIDTH-1:0] m_q     = '0;
  logic             m_valid = 1'b0;
  logic             m_ovr   = 1'b0;
  logic             m_perr  = 1'b0;

  sipo_frame_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .ready(ready),
    .clr_ovr(clr_ovr), .q_out(q_out), .valid(valid), .busy(busy),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // One clock: set inputs, pass the rising edge, settle before sampling.
  task automatic step(input logic e, input logic d, input logic r, input logic c);
    en = e; din = d; ready = r; clr_ovr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    n_total++;
    if (q_out !== m_q) $display("FAIL %s q_out: got %h expected %h", tag, q_out, m_q);
    else n_pass++;
    n_total++;
    if (valid !== m_valid) $display("FAIL %s valid: got %b expected %b", tag, valid, m_valid);
    else n_pass++;
    n_total++;
    if (overrun !== m_ovr) $display("FAIL %s overrun: got %b expected %b", tag, overrun, m_ovr);
    else n_pass++;
    n_total++;
    if (parity_err !== m_perr) $display("FAIL %s parity_err: got %b expected %b", tag, parity_err, m_perr);
    else n_pass++;
  endtask

  // Sends start bit, data MSB first, optional parity bit; en gaps up to gap_max.
  task automatic send_frame(input logic [WIDTH-1:0] w, input logic p, input logic rdy_last,
                            input logic clr_last, input int gap_max, input string tag);
    int busy_n;
    logic b;
    busy_n = 0;
    for (int k = 0; k <= NB; k++) begin
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (k == 0) b = 1'b1;
      else if (k <= WIDTH) b = w[WIDTH-k];
      else b = p;
      step(1'b1, b, (k == NB) ? rdy_last : 1'b0, (k == NB) ? clr_last : 1'b0);
      if (busy === 1'b1) busy_n++;
    end
    if (m_valid && !rdy_last) begin
      m_ovr = 1'b1;
    end else begin
      m_q = w;
      m_valid = 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
      m_perr = ^{w, p};
`endif
      if (clr_last) m_ovr = 1'b0;
    end
    n_total++;
    if (busy_n !== NB) $display("FAIL %s busy_ticks: got %0d expected %0d", tag, busy_n, NB);
    else n_pass++;
    check_outputs(tag);
  endtask

  task automatic consume(input string tag);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    m_valid = 1'b0;
    check_outputs(tag);
  endtask

  task automatic clear_ovr(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    m_ovr = 1'b0;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_q = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    check_outputs("reset");
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy);
    else n_pass++;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    send_frame(4'b1011, 1'b1, 1'b0, 1'b0, 0, "basic");
    consume("basic_consume");
  endtask

  task automatic test_idle_gating();
    int busy_seen;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (busy !== 1'b0) busy_seen++;
    end
    // din=1 without en must not start a frame
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (busy !== 1'b0) busy_seen++;
    end
    n_total++;
    if (busy_seen != 0) $display("FAIL idle_busy: got %0d busy cycles expected 0", busy_seen);
    else n_pass++;
    check_outputs("idle");
    send_frame(4'b0110, 1'b0, 1'b0, 1'b0, 1, "gated");
    consume("gated_consume");
  endtask

  task automatic test_back_to_back();
    send_frame(4'h9, 1'b0, 1'b0, 1'b0, 0, "b2b_first");
    send_frame(4'h6, 1'b0, 1'b1, 1'b0, 0, "b2b_second");
    consume("b2b_consume");
  endtask

  task automatic test_overrun();
    send_frame(4'h3, 1'b0, 1'b0, 1'b0, 0, "ovr_first");
    send_frame(4'hC, 1'b1, 1'b0, 1'b0, 0, "ovr_drop");
    clear_ovr("ovr_clear");
    // Drop and clear on the same edge: the set must win.
    send_frame(4'h5, 1'b0, 1'b0, 1'b1, 0, "ovr_set_wins");
    clear_ovr("ovr_clear2");
    consume("ovr_consume");
  endtask

`ifdef SIPO_FRAME_PARITY_EN
  task automatic test_parity();
    send_frame(4'b1010, 1'b1, 1'b0, 1'b0, 0, "parity_bad");
    consume("parity_c1");
    send_frame(4'b1010, 1'b0, 1'b0, 1'b0, 0, "parity_good");
    consume("parity_c2");
  endtask
`endif

  task automatic test_reset_mid_frame();
    send_frame(4'hE, 1'b0, 1'b0, 1'b0, 0, "pre_reset");
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    n_total++;
    if (busy !== 1'b0) $display("FAIL async_reset busy: got %b expected 0", busy);
    else n_pass++;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0001, 1'b1, 1'b0, 1'b0, 0, "post_reset");
    consume("post_reset_consume");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] w;
      int act;
      w = WIDTH'($urandom);
      send_frame(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), 2, "random");
      act = int'($urandom_range(0, 3));
      if (act == 0) consume("random_consume");
      else if (act == 1) clear_ovr("random_clear");
      else step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_gating();
    test_back_to_back();
    test_overrun();
`ifdef SIPO_FRAME_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
